// File: rtl/lsu_pkg.sv
// Load/store operation encoding shared by the decode and memory stages.
package lsu_pkg;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB   = 4'd1,
    LSU_LH   = 4'd2,
    LSU_LW   = 4'd3,
    LSU_LBU  = 4'd4,
    LSU_LHU  = 4'd5,
    LSU_SB   = 4'd6,
    LSU_SH   = 4'd7,
    LSU_SW   = 4'd8
  } lsuop_t;

endpackage

// File: rtl/mem_stage_pkg.sv
// Types and constants for the handshaked memory stage.
// Optional build macro: MEM_STAGE_TIMEOUT_EN (bus-error abort after a response timeout).
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // Default field widths; the stage itself takes these as parameters.
  localparam int XLEN_DEF  = 32;
  localparam int RF_AW_DEF = 5;
  localparam int WB_SEL_W  = 2;

  // Base byte-enable patterns; byte and half masks are shifted into lane position.
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/mem_stage_hs_lsu_align.sv
// Lane alignment for the memory stage: store mask/data replication,
// misalignment detection and load byte/half extraction with extension.
module lsu_align
  import lsu_pkg::*;
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  lsuop_t            op_i,
  input  logic [1:0]        off_i,
  input  logic [XLEN-1:0]   sdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN/8-1:0] mask_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   ldata_o,
  output logic              we_o,
  output logic              misalign_o
);

  logic [XLEN-1:0] laneShift;
  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;

  // Move the addressed byte down to lane 0 and pick the addressed half.
  always_comb begin
    laneShift = rdata_i >> {off_i, 3'b000};
    loadByte  = laneShift[7:0];
    loadHalf  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Decode the operation into mask, write data, direction and alignment fault.
  always_comb begin
    mask_o     = MASK_W;
    wdata_o    = sdata_i;
    we_o       = 1'b0;
    misalign_o = 1'b0;
    unique case (op_i)
      LSU_SB: begin
        we_o    = 1'b1;
        mask_o  = MASK_B << off_i;
        wdata_o = {(XLEN/8){sdata_i[7:0]}};
      end
      LSU_SH: begin
        we_o       = 1'b1;
        mask_o     = off_i[1] ? (MASK_H << 2) : MASK_H;
        wdata_o    = {(XLEN/16){sdata_i[15:0]}};
        misalign_o = off_i[0];
      end
      LSU_SW: begin
        we_o       = 1'b1;
        misalign_o = |off_i;
      end
      LSU_LH, LSU_LHU: misalign_o = off_i[0];
      LSU_LW:          misalign_o = |off_i;
      default: ;
    endcase
  end

  // Sign or zero extend the selected load lane.
  always_comb begin
    ldata_o = rdata_i;
    unique case (op_i)
      LSU_LB:  ldata_o = {{(XLEN-8){loadByte[7]}}, loadByte};
      LSU_LBU: ldata_o = {{(XLEN-8){1'b0}}, loadByte};
      LSU_LH:  ldata_o = {{(XLEN-16){loadHalf[15]}}, loadHalf};
      LSU_LHU: ldata_o = {{(XLEN-16){1'b0}}, loadHalf};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory pipeline stage with valid/ready request and response handshake.
// Optional build macro: MEM_STAGE_TIMEOUT_EN aborts a WAIT after TIMEOUT_CYC
// cycles with out_bus_err; without it the stage waits for the response forever.
module mem_stage_hs
  import lsu_pkg::*;
  import mem_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RF_AW       = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RF_AW-1:0]  in_rd,
  input  logic [XLEN-1:0]   in_opr_b,
  input  logic [XLEN-1:0]   in_opr_res,
  input  logic [XLEN-1:0]   in_pc4,
  input  lsuop_t            in_lsuop,
  input  logic              in_rf_en,
  input  logic              in_dm_en,
  input  logic [1:0]        in_wb_sel,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN/8-1:0] mem_req_mask,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_opr_res,
  output logic [XLEN-1:0]   out_lsu_rdata,
  output logic [XLEN-1:0]   out_pc4,
  output logic [RF_AW-1:0]  out_rd,
  output logic              out_rf_en,
  output logic [1:0]        out_wb_sel,
  output logic              out_misalign,
  output logic              out_bus_err
);

  if (XLEN != 32) begin : g_xlen_check
    $error("mem_stage_hs supports only XLEN=32");
  end
  if (TIMEOUT_CYC < 1) begin : g_timeout_check
    $error("mem_stage_hs needs TIMEOUT_CYC >= 1");
  end

  mem_state_t        state_q, state_d;
  logic              drop_q, drop_d;
  logic [XLEN-1:0]   reqAddr_q, reqAddr_d;
  logic [XLEN/8-1:0] reqMask_q, reqMask_d;
  logic [XLEN-1:0]   reqWdata_q, reqWdata_d;
  logic              reqWe_q, reqWe_d;
  lsuop_t            lsuop_q, lsuop_d;
  logic [RF_AW-1:0]  rd_q, rd_d;
  logic              rfEn_q, rfEn_d;
  logic [1:0]        wbSel_q, wbSel_d;
  logic [XLEN-1:0]   oprRes_q, oprRes_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;

  logic              outValid_q, outValid_d;
  logic [XLEN-1:0]   outOprRes_q, outOprRes_d;
  logic [XLEN-1:0]   outLsuRdata_q, outLsuRdata_d;
  logic [XLEN-1:0]   outPc4_q, outPc4_d;
  logic [RF_AW-1:0]  outRd_q, outRd_d;
  logic              outRfEn_q, outRfEn_d;
  logic [1:0]        outWbSel_q, outWbSel_d;
  logic              outMisalign_q, outMisalign_d;
  logic              outBusErr_q, outBusErr_d;

  lsuop_t            alignOp;
  logic [1:0]        alignOff;
  logic [XLEN/8-1:0] alignMask;
  logic [XLEN-1:0]   alignWdata;
  logic [XLEN-1:0]   alignLdata;
  logic              alignWe;
  logic              alignMisalign;
  logic              timeoutHit;

  // The aligner sees the incoming instruction while idle and the latched one otherwise.
  always_comb begin
    alignOp  = (state_q == IDLE) ? in_lsuop : lsuop_q;
    alignOff = (state_q == IDLE) ? in_opr_res[1:0] : oprRes_q[1:0];
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .op_i       (alignOp),
    .off_i      (alignOff),
    .sdata_i    (in_opr_b),
    .rdata_i    (mem_rsp_rdata),
    .mask_o     (alignMask),
    .wdata_o    (alignWdata),
    .ldata_o    (alignLdata),
    .we_o       (alignWe),
    .misalign_o (alignMisalign)
  );

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] waitCnt_q;

  // Count cycles spent in WAIT; any other state clears it so each wait starts at zero.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                 waitCnt_q <= '0;
    else if (state_q == WAIT) waitCnt_q <= waitCnt_q + 1'b1;
    else                      waitCnt_q <= '0;
  end

  assign timeoutHit = (state_q == WAIT) && !mem_rsp_valid &&
                      (waitCnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // Next-state, request latching and WB payload update for the three-state handshake.
  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    reqAddr_d     = reqAddr_q;
    reqMask_d     = reqMask_q;
    reqWdata_d    = reqWdata_q;
    reqWe_d       = reqWe_q;
    lsuop_d       = lsuop_q;
    rd_d          = rd_q;
    rfEn_d        = rfEn_q;
    wbSel_d       = wbSel_q;
    oprRes_d      = oprRes_q;
    pc4_d         = pc4_q;
    outValid_d    = 1'b0;
    outOprRes_d   = outOprRes_q;
    outLsuRdata_d = outLsuRdata_q;
    outPc4_d      = outPc4_q;
    outRd_d       = outRd_q;
    outRfEn_d     = outRfEn_q;
    outWbSel_d    = outWbSel_q;
    outMisalign_d = outMisalign_q;
    outBusErr_d   = outBusErr_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          if (!in_dm_en || alignMisalign) begin
            outValid_d    = 1'b1;
            outOprRes_d   = in_opr_res;
            outLsuRdata_d = '0;
            outPc4_d      = in_pc4;
            outRd_d       = in_rd;
            outWbSel_d    = in_wb_sel;
            outMisalign_d = in_dm_en;
            outRfEn_d     = in_rf_en && !in_dm_en;
            outBusErr_d   = 1'b0;
          end else begin
            state_d    = REQ;
            drop_d     = 1'b0;
            reqAddr_d  = {in_opr_res[XLEN-1:2], 2'b00};
            reqMask_d  = alignMask;
            reqWdata_d = alignWdata;
            reqWe_d    = alignWe;
            lsuop_d    = in_lsuop;
            rd_d       = in_rd;
            rfEn_d     = in_rf_en;
            wbSel_d    = in_wb_sel;
            oprRes_d   = in_opr_res;
            pc4_d      = in_pc4;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          drop_d  = flush;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush) drop_d = 1'b1;
        if (mem_rsp_valid || timeoutHit) begin
          state_d = IDLE;
          if (!(drop_q || flush)) begin
            outValid_d    = 1'b1;
            outOprRes_d   = oprRes_q;
            outPc4_d      = pc4_q;
            outRd_d       = rd_q;
            outWbSel_d    = wbSel_q;
            outMisalign_d = 1'b0;
            outBusErr_d   = timeoutHit;
            outRfEn_d     = rfEn_q && !timeoutHit;
            outLsuRdata_d = (reqWe_q || timeoutHit) ? '0 : alignLdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and WB register update.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= IDLE;
      drop_q        <= 1'b0;
      reqAddr_q     <= '0;
      reqMask_q     <= '0;
      reqWdata_q    <= '0;
      reqWe_q       <= 1'b0;
      lsuop_q       <= LSU_NONE;
      rd_q          <= '0;
      rfEn_q        <= 1'b0;
      wbSel_q       <= '0;
      oprRes_q      <= '0;
      pc4_q         <= '0;
      outValid_q    <= 1'b0;
      outOprRes_q   <= '0;
      outLsuRdata_q <= '0;
      outPc4_q      <= '0;
      outRd_q       <= '0;
      outRfEn_q     <= 1'b0;
      outWbSel_q    <= '0;
      outMisalign_q <= 1'b0;
      outBusErr_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      reqAddr_q     <= reqAddr_d;
      reqMask_q     <= reqMask_d;
      reqWdata_q    <= reqWdata_d;
      reqWe_q       <= reqWe_d;
      lsuop_q       <= lsuop_d;
      rd_q          <= rd_d;
      rfEn_q        <= rfEn_d;
      wbSel_q       <= wbSel_d;
      oprRes_q      <= oprRes_d;
      pc4_q         <= pc4_d;
      outValid_q    <= outValid_d;
      outOprRes_q   <= outOprRes_d;
      outLsuRdata_q <= outLsuRdata_d;
      outPc4_q      <= outPc4_d;
      outRd_q       <= outRd_d;
      outRfEn_q     <= outRfEn_d;
      outWbSel_q    <= outWbSel_d;
      outMisalign_q <= outMisalign_d;
      outBusErr_q   <= outBusErr_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_we    = reqWe_q;
  assign mem_req_mask  = reqMask_q;
  assign mem_req_addr  = reqAddr_q;
  assign mem_req_wdata = reqWdata_q;
  assign out_valid     = outValid_q;
  assign out_opr_res   = outOprRes_q;
  assign out_lsu_rdata = outLsuRdata_q;
  assign out_pc4       = outPc4_q;
  assign out_rd        = outRd_q;
  assign out_rf_en     = outRfEn_q;
  assign out_wb_sel    = outWbSel_q;
  assign out_misalign  = outMisalign_q;
  assign out_bus_err   = outBusErr_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs.
// Optional build macro: MEM_STAGE_TIMEOUT_EN selects the timeout scenario.
module tb_mem_stage_hs;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [4:0]  inRd;
  logic [31:0] inOprB;
  logic [31:0] inOprRes;
  logic [31:0] inPc4;
  lsuop_t      inLsuop;
  logic        inRfEn;
  logic        inDmEn;
  logic [1:0]  inWbSel;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [3:0]  reqMask;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        outValid;
  logic [31:0] outOprRes;
  logic [31:0] outLsuRdata;
  logic [31:0] outPc4;
  logic [4:0]  outRd;
  logic        outRfEn;
  logic [1:0]  outWbSel;
  logic        outMisalign;
  logic        outBusErr;

  int checkCount = 0;
  int failCount  = 0;

  mem_stage_hs #(.XLEN(32), .RF_AW(5), .TIMEOUT_CYC(10)) dut (
    .clk           (clk),
    .arst          (arst),
    .flush         (flush),
    .in_valid      (inValid),
    .in_ready      (inReady),
    .in_rd         (inRd),
    .in_opr_b      (inOprB),
    .in_opr_res    (inOprRes),
    .in_pc4        (inPc4),
    .in_lsuop      (inLsuop),
    .in_rf_en      (inRfEn),
    .in_dm_en      (inDmEn),
    .in_wb_sel     (inWbSel),
    .mem_req_valid (reqValid),
    .mem_req_ready (reqReady),
    .mem_req_we    (reqWe),
    .mem_req_mask  (reqMask),
    .mem_req_addr  (reqAddr),
    .mem_req_wdata (reqWdata),
    .mem_rsp_valid (rspValid),
    .mem_rsp_rdata (rspRdata),
    .out_valid     (outValid),
    .out_opr_res   (outOprRes),
    .out_lsu_rdata (outLsuRdata),
    .out_pc4       (outPc4),
    .out_rd        (outRd),
    .out_rf_en     (outRfEn),
    .out_wb_sel    (outWbSel),
    .out_misalign  (outMisalign),
    .out_bus_err   (outBusErr)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input lsuop_t op, input logic dmEn,
                               input logic rfEn, input logic [4:0] rd,
                               input logic [31:0] res, input logic [31:0] oprB);
    inValid  = valid;
    inLsuop  = op;
    inDmEn   = dmEn;
    inRfEn   = rfEn;
    inRd     = rd;
    inOprRes = res;
    inOprB   = oprB;
    inPc4    = res + 32'd4;
    inWbSel  = 2'b01;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
  endtask

  // Accept at the next edge, memory accepts one edge later, response two edges after that.
  task automatic runMem(input logic [31:0] rdata);
    tick();
    inValid = 1'b0;
    tick();
    tick();
    rspValid = 1'b1;
    rspRdata = rdata;
    tick();
    rspValid = 1'b0;
  endtask

  initial begin
    arst     = 1'b1;
    flush    = 1'b0;
    reqReady = 1'b0;
    rspValid = 1'b0;
    rspRdata = '0;
    applyStimulus(1'b0, LSU_NONE, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    repeat (2) tick();
    checkOutput("rst_out_valid", 32'(outValid), 32'h0);
    checkOutput("rst_req_valid", 32'(reqValid), 32'h0);
    checkOutput("rst_in_ready", 32'(inReady), 32'h1);
    checkOutput("rst_opr_res", outOprRes, 32'h0);
    arst = 1'b0;
    tick();

    // ALU op passes through in one cycle with no memory request.
    applyStimulus(1'b1, LSU_NONE, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0);
    tick();
    inValid = 1'b0;
    checkOutput("add_valid", 32'(outValid), 32'h1);
    checkOutput("add_res", outOprRes, 32'h0000_1234);
    checkOutput("add_pc4", outPc4, 32'h0000_1238);
    checkOutput("add_rd", 32'(outRd), 32'd5);
    checkOutput("add_rf_en", 32'(outRfEn), 32'h1);
    checkOutput("add_no_req", 32'(reqValid), 32'h0);
    tick();
    checkOutput("add_pulse_end", 32'(outValid), 32'h0);
    checkOutput("add_hold", outOprRes, 32'h0000_1234);

    // LB from byte 3, sign extended.
    reqReady = 1'b1;
    applyStimulus(1'b1, LSU_LB, 1'b1, 1'b1, 5'd7, 32'h0000_0103, 32'h0);
    tick();
    inValid = 1'b0;
    checkOutput("lb_req_valid", 32'(reqValid), 32'h1);
    checkOutput("lb_req_addr", reqAddr, 32'h0000_0100);
    checkOutput("lb_req_mask", 32'(reqMask), 32'hF);
    checkOutput("lb_req_we", 32'(reqWe), 32'h0);
    checkOutput("lb_in_ready", 32'(inReady), 32'h0);
    tick();
    checkOutput("lb_wait_req", 32'(reqValid), 32'h0);
    tick();
    checkOutput("lb_wait_novalid", 32'(outValid), 32'h0);
    rspValid = 1'b1;
    rspRdata = 32'h80FF_FFFF;
    tick();
    rspValid = 1'b0;
    checkOutput("lb_valid", 32'(outValid), 32'h1);
    checkOutput("lb_rdata", outLsuRdata, 32'hFFFF_FF80);
    checkOutput("lb_rd", 32'(outRd), 32'd7);
    checkOutput("lb_in_ready", 32'(inReady), 32'h1);

    // LBU on the same data, zero extended.
    applyStimulus(1'b1, LSU_LBU, 1'b1, 1'b1, 5'd8, 32'h0000_0103, 32'h0);
    runMem(32'h80FF_FFFF);
    checkOutput("lbu_rdata", outLsuRdata, 32'h0000_0080);
    checkOutput("lbu_valid", 32'(outValid), 32'h1);

    // LH from the upper half, sign extended.
    applyStimulus(1'b1, LSU_LH, 1'b1, 1'b1, 5'd9, 32'h0000_0042, 32'h0);
    runMem(32'h8001_7FFF);
    checkOutput("lh_rdata", outLsuRdata, 32'hFFFF_8001);

    // SH to the upper half with memory stalling four cycles.
    reqReady = 1'b0;
    applyStimulus(1'b1, LSU_SH, 1'b1, 1'b0, 5'd0, 32'h0000_0202, 32'h1234_ABCD);
    tick();
    applyStimulus(1'b1, LSU_SW, 1'b1, 1'b0, 5'd0, 32'h0000_0000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("sh_req_valid", 32'(reqValid), 32'h1);
      checkOutput("sh_req_addr", reqAddr, 32'h0000_0200);
      checkOutput("sh_req_mask", 32'(reqMask), 32'hC);
      checkOutput("sh_req_wdata", reqWdata, 32'hABCD_ABCD);
      checkOutput("sh_req_we", 32'(reqWe), 32'h1);
      checkOutput("sh_in_ready", 32'(inReady), 32'h0);
      tick();
    end
    inValid  = 1'b0;
    reqReady = 1'b1;
    tick();
    checkOutput("sh_wait_ready", 32'(inReady), 32'h0);
    rspValid = 1'b1;
    rspRdata = 32'hFFFF_FFFF;
    tick();
    rspValid = 1'b0;
    checkOutput("sh_valid", 32'(outValid), 32'h1);
    checkOutput("sh_rdata", outLsuRdata, 32'h0);
    checkOutput("sh_rf_en", 32'(outRfEn), 32'h0);

    // SB to byte 1: mask and replicated data.
    applyStimulus(1'b1, LSU_SB, 1'b1, 1'b0, 5'd0, 32'h0000_0011, 32'h0000_005A);
    tick();
    inValid = 1'b0;
    checkOutput("sb_req_mask", 32'(reqMask), 32'h2);
    checkOutput("sb_req_wdata", reqWdata, 32'h5A5A_5A5A);
    checkOutput("sb_req_addr", reqAddr, 32'h0000_0010);
    tick();
    rspValid = 1'b1;
    tick();
    rspValid = 1'b0;
    checkOutput("sb_valid", 32'(outValid), 32'h1);

    // Misaligned LW: flagged, no write-back, no request.
    applyStimulus(1'b1, LSU_LW, 1'b1, 1'b1, 5'd3, 32'h0000_0101, 32'h0);
    tick();
    inValid = 1'b0;
    checkOutput("mis_valid", 32'(outValid), 32'h1);
    checkOutput("mis_flag", 32'(outMisalign), 32'h1);
    checkOutput("mis_rf_en", 32'(outRfEn), 32'h0);
    checkOutput("mis_no_req", 32'(reqValid), 32'h0);
    checkOutput("mis_in_ready", 32'(inReady), 32'h1);
    tick();
    checkOutput("mis_no_req2", 32'(reqValid), 32'h0);

    // Flush in WAIT: response consumed silently, next op waits for it.
    applyStimulus(1'b1, LSU_LW, 1'b1, 1'b1, 5'd4, 32'h0000_0300, 32'h0);
    tick();
    inValid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b1, LSU_NONE, 1'b0, 1'b1, 5'd6, 32'h0000_5555, 32'h0);
    checkOutput("fw_in_ready", 32'(inReady), 32'h0);
    tick();
    tick();
    rspValid = 1'b1;
    rspRdata = 32'hDEAD_BEEF;
    tick();
    rspValid = 1'b0;
    checkOutput("fw_no_valid", 32'(outValid), 32'h0);
    checkOutput("fw_idle", 32'(inReady), 32'h1);
    tick();
    inValid = 1'b0;
    checkOutput("fw_next_valid", 32'(outValid), 32'h1);
    checkOutput("fw_next_res", outOprRes, 32'h0000_5555);

    // Flush in IDLE drops the incoming instruction.
    applyStimulus(1'b1, LSU_NONE, 1'b0, 1'b1, 5'd1, 32'h0000_7777, 32'h0);
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    inValid = 1'b0;
    checkOutput("fi_no_valid", 32'(outValid), 32'h0);
    checkOutput("fi_hold", outOprRes, 32'h0000_5555);

    // Flush in REQ before acceptance withdraws the request.
    reqReady = 1'b0;
    applyStimulus(1'b1, LSU_LW, 1'b1, 1'b1, 5'd2, 32'h0000_0400, 32'h0);
    tick();
    inValid = 1'b0;
    flush   = 1'b1;
    checkOutput("fr_req_valid", 32'(reqValid), 32'h1);
    tick();
    flush = 1'b0;
    checkOutput("fr_withdrawn", 32'(reqValid), 32'h0);
    checkOutput("fr_idle", 32'(inReady), 32'h1);
    checkOutput("fr_no_valid", 32'(outValid), 32'h0);

    // LW that never gets a response.
    reqReady = 1'b1;
    applyStimulus(1'b1, LSU_LW, 1'b1, 1'b1, 5'd9, 32'h0000_0500, 32'h0);
    tick();
    inValid = 1'b0;
    tick();
`ifdef MEM_STAGE_TIMEOUT_EN
    repeat (9) tick();
    checkOutput("to_pending", 32'(outValid), 32'h0);
    checkOutput("to_pending_ready", 32'(inReady), 32'h0);
    tick();
    checkOutput("to_valid", 32'(outValid), 32'h1);
    checkOutput("to_bus_err", 32'(outBusErr), 32'h1);
    checkOutput("to_rf_en", 32'(outRfEn), 32'h0);
    checkOutput("to_idle", 32'(inReady), 32'h1);
`else
    repeat (20) tick();
    checkOutput("hang_no_valid", 32'(outValid), 32'h0);
    checkOutput("hang_ready", 32'(inReady), 32'h0);
    checkOutput("hang_bus_err", 32'(outBusErr), 32'h0);
`endif

    // Reset mid-stream returns to IDLE immediately; a late response is ignored.
    applyStimulus(1'b1, LSU_LW, 1'b1, 1'b1, 5'd9, 32'h0000_0600, 32'h0);
    tick();
    inValid = 1'b0;
    tick();
    #2;
    arst = 1'b1;
    #1;
    checkOutput("arst_idle", 32'(inReady), 32'h1);
    checkOutput("arst_opr_res", outOprRes, 32'h0);
    tick();
    arst     = 1'b0;
    rspValid = 1'b1;
    rspRdata = 32'h1111_1111;
    tick();
    rspValid = 1'b0;
    checkOutput("late_rsp_ignored", 32'(outValid), 32'h0);
    checkOutput("late_rsp_rdata", outLsuRdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Memory stage with a valid/ready request and response handshake to shared memory. It replaces the single-cycle combinational data-memory path.
- Sits between the EX/MEM pipeline register and the WB register.
- Tolerates memory latency of any number of cycles, stalling upstream meanwhile.
- Detects misaligned accesses and raises a flag instead of issuing a request.
- Data width and register-address width are parametrised.

Parameters:
XLEN, 32, data/address width; only 32 is supported, asserted at elaboration
RF_AW, 5, register-file address width (rd)
TIMEOUT_CYC, 255, cycles waiting on rsp before abort (only with MEM_STAGE_TIMEOUT_EN)

Ports:
clk  in  1  clock
arst  in  1  asynchronous active-high reset
flush  in  1  kill the current instruction (branch/trap)
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; low = stall upstream
in_rd  in  RF_AW  destination register
in_opr_b  in  XLEN  store data
in_opr_res  in  XLEN  ALU result / effective address
in_pc4  in  XLEN  pc+4
in_lsuop  in  lsuop_t  LB/LH/LW/LBU/LHU/SB/SH/SW
in_rf_en  in  1  register write enable
in_dm_en  in  1  memory access enable
in_wb_sel  in  2  writeback select
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = store
mem_req_mask  out  XLEN/8  byte enables
mem_req_addr  out  XLEN  word-aligned address (addr[1:0]=0)
mem_req_wdata  out  XLEN  lane-shifted store data
mem_rsp_valid  in  1  response / store ack valid (one-cycle pulse)
mem_rsp_rdata  in  XLEN  raw load word
out_valid  out  1  WB register valid
out_opr_res, out_lsu_rdata, out_pc4  out  XLEN  to WB
out_rd  out  RF_AW  to WB
out_rf_en  out  1  to WB
out_wb_sel  out  2  to WB
out_misalign  out  1  instruction had a misaligned address; rf_en forced 0
out_bus_err  out  1  timeout abort (tied 0 when the feature is off)

Behaviour:
- Reset (async, arst=1): state IDLE, all out_* = 0, mem_req_valid=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE
  - in_ready=1.
  - Non-memory op (in_dm_en=0), or misaligned op: output register loaded the next edge, 1-cycle latency.
  - Misaligned means: half access with addr[0]=1, or word access with addr[1:0]≠0. Result: out_misalign=1, out_rf_en=0, no request issued.
  - Aligned memory op: request fields are latched and the FSM goes to REQ. in_ready drops the next cycle.
- REQ
  - mem_req_valid=1; fields are held stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready → WAIT.
- WAIT
  - On mem_rsp_valid:
    - Load: lane extract and sign/zero extension into out_lsu_rdata.
    - Store: out_lsu_rdata=0.
  - out_valid=1 for one cycle, FSM → IDLE.
  - The response cannot arrive in the same cycle as its accept; it arrives at least one cycle later.
  - Minimum memory-op latency: 3 cycles, in → out_valid.
- in_ready = (state==IDLE). A new instruction is accepted only in IDLE.
- out_valid: pulses for one cycle per completed instruction, 0 otherwise. The out_* payload holds its value between pulses.
- Store mask/data
  - SB: mask = 1<<addr[1:0], byte replicated on all lanes.
  - SH: mask = 0011 or 1100, half replicated.
  - SW: mask = 1111.
  - Loads: mask = 1111, we=0.
- flush
  - In IDLE: the incoming instruction is dropped, out_valid=0.
  - In REQ: the request is withdrawn only if not yet accepted; go to IDLE.
  - In WAIT: set a drop flag and stay in WAIT until rsp. The response is consumed and discarded, out_valid=0.
  - Only one request is outstanding at any time.
- Simultaneous flush and mem_req_ready in REQ: the request counts as accepted; follow the WAIT drop rule.
- arst mid-transaction: immediate return to IDLE. Any late response while in IDLE is ignored.

Optional Feature:
MEM_STAGE_TIMEOUT_EN
- Defined:
  - An 8+-bit counter (width $clog2(TIMEOUT_CYC+1)) counts cycles in WAIT.
  - On reaching TIMEOUT_CYC: FSM → IDLE, out_valid=1, out_bus_err=1, out_rf_en=0.
  - The counter clears on entering WAIT.
- Undefined: no counter; out_bus_err tied 0; WAIT waits forever.

Decomposition:
- mem_stage_pkg gains:
  - mem_state_t enum (IDLE/REQ/WAIT);
  - parametrised-width in/out field definitions;
  - constants MASK_B/MASK_H/MASK_W.
- lsuop_t stays in lsu_pkg.
- One natural sub-module, lsu_align: combinational store mask/data shift, misalign detect, and load extraction/extension.

Test Plan:
- ADD, opr_res=0x1234, rf_en=1 → out_valid next cycle, out_opr_res=0x1234, no mem_req_valid.
- LB, addr 0x103, rsp_rdata=0x80FF_FFFF, ready=1, rsp 2 cycles later → req_addr=0x100, mask 1111, out_lsu_rdata=0xFFFF_FF80. LBU on the same data → 0x0000_0080.
- SH, addr 0x202, opr_b=0xABCD, ready held low 4 cycles → req fields stable, mask 1100, wdata=0xABCD_ABCD, in_ready=0 throughout.
- LW, addr 0x101 → out_misalign=1, out_rf_en=0, mem_req_valid never asserted.
- LW accepted, flush during WAIT, rsp arrives 3 cycles later → no out_valid; next instruction accepted after rsp.
- (MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYC=10) LW, no rsp → out_bus_err=1 exactly 10 cycles after entering WAIT, FSM back to IDLE.
